// File: rtl/wombat_axil_regbank_if.sv
// rtl/wombat_axil_regbank_if.sv - AXI4-Lite slave bus bundle for the wombat register bank
interface wombat_axil_regbank_if #(
    parameter int C_ADDR_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [31:0]             s_axi_wdata;
    logic [3:0]              s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [C_ADDR_WIDTH-1:0] s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [31:0]             s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/wombat_axil_regbank.sv
// rtl/wombat_axil_regbank.sv - parametrised AXI4-Lite register bank (ID, RW, RO, clear-on-read)
module wombat_axil_regbank #(
    parameter int                     C_ADDR_WIDTH   = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDRESS = '0,
    parameter logic [31:0]            C_ID_VALUE     = 32'h5744_0001,
    parameter int                     C_NUM_RW       = 4,
    parameter int                     C_NUM_RO       = 4,
    parameter int                     C_NUM_COR      = 2,
    parameter logic [32*C_NUM_RW-1:0] C_RW_DEFAULT   = '0
) (
    input  logic                     clk,
    input  logic                     resetn,
    wombat_axil_regbank_if.slave     s_axi,
    output logic [32*C_NUM_RW-1:0]   rw_regs,
    output logic [C_NUM_RW-1:0]      rw_wr_pulse,
    input  logic [32*C_NUM_RO-1:0]   ro_regs,
    input  logic [32*C_NUM_COR-1:0]  cor_regs,
    output logic [C_NUM_COR-1:0]     cor_clear
);

    typedef enum logic [2:0] {K_ID, K_RW, K_RO, K_COR, K_NONE} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [4:0] idx;
    } dec_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Map an absolute address to a register class and index within that class.
    function automatic dec_t decode(input logic [C_ADDR_WIDTH-1:0] addr);
        logic [C_ADDR_WIDTH-1:0] off;
        logic [9:0]              word;
        dec_t                    d;
        off    = addr - C_BASE_ADDRESS;
        word   = 10'(off >> 2);
        d.kind = K_NONE;
        d.idx  = '0;
        if (addr >= C_BASE_ADDRESS && off < C_ADDR_WIDTH'(32'h1000)) begin
            if (word == 10'd0) begin
                d.kind = K_ID;
            end else if (word >= 10'd4 && word < 10'(4 + C_NUM_RW)) begin
                d.kind = K_RW;
                d.idx  = 5'(word - 10'd4);
            end else if (word >= 10'd64 && word < 10'(64 + C_NUM_RO)) begin
                d.kind = K_RO;
                d.idx  = 5'(word - 10'd64);
            end else if (word >= 10'd128 && word < 10'(128 + C_NUM_COR)) begin
                d.kind = K_COR;
                d.idx  = 5'(word - 10'd128);
            end
        end
        return d;
    endfunction

    logic                    r_aw_full;
    logic [C_ADDR_WIDTH-1:0] r_awaddr;
    logic                    r_w_full;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [31:0]             r_rdata;
    logic [1:0]              r_rresp;
    logic [32*C_NUM_RW-1:0]  r_rw_regs;
    logic [C_NUM_RW-1:0]     r_rw_wr_pulse;
    logic [C_NUM_COR-1:0]    r_cor_clear;

    logic                    w_awready;
    logic                    w_wready;
    logic                    w_arready;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_do_write;
    dec_t                    w_wr_dec;
    dec_t                    w_rd_dec;
    logic [31:0]             w_rdata;
    logic [1:0]              w_rresp;
    logic [1:0]              w_bresp;
    logic [C_NUM_COR-1:0]    w_cor_hit;

    // Readies depend on resetn directly so they are low throughout reset.
    assign w_awready  = ~r_aw_full & ~r_bvalid & resetn;
    assign w_wready   = ~r_w_full & ~r_bvalid & resetn;
    assign w_arready  = ~r_rvalid & resetn;
    assign w_aw_hs    = s_axi.s_axi_awvalid & w_awready;
    assign w_w_hs     = s_axi.s_axi_wvalid & w_wready;
    assign w_ar_hs    = s_axi.s_axi_arvalid & w_arready;
    assign w_do_write = r_aw_full & r_w_full;
    assign w_wr_dec   = decode(r_awaddr);
    assign w_rd_dec   = decode(s_axi.s_axi_araddr);

    always_comb begin
        w_rdata   = 32'hDEAD_BEEF;
        w_rresp   = RESP_DECERR;
        w_cor_hit = '0;
        case (w_rd_dec.kind)
            K_ID: begin
                w_rdata = C_ID_VALUE;
                w_rresp = RESP_OKAY;
            end
            K_RW: begin
                w_rresp = RESP_OKAY;
                for (int i = 0; i < C_NUM_RW; i++)
                    if (w_rd_dec.idx == 5'(i)) w_rdata = r_rw_regs[32*i +: 32];
            end
            K_RO: begin
                w_rresp = RESP_OKAY;
                for (int i = 0; i < C_NUM_RO; i++)
                    if (w_rd_dec.idx == 5'(i)) w_rdata = ro_regs[32*i +: 32];
            end
            K_COR: begin
                w_rresp = RESP_OKAY;
                for (int i = 0; i < C_NUM_COR; i++)
                    if (w_rd_dec.idx == 5'(i)) begin
                        w_rdata      = cor_regs[32*i +: 32];
                        w_cor_hit[i] = 1'b1;
                    end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_wr_dec.kind)
            K_RW:    w_bresp = RESP_OKAY;
            K_NONE:  w_bresp = RESP_DECERR;
            default: w_bresp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_aw_full     <= 1'b0;
            r_awaddr      <= '0;
            r_w_full      <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_bvalid      <= 1'b0;
            r_bresp       <= RESP_OKAY;
            r_rvalid      <= 1'b0;
            r_rdata       <= '0;
            r_rresp       <= RESP_OKAY;
            r_rw_regs     <= C_RW_DEFAULT;
            r_rw_wr_pulse <= '0;
            r_cor_clear   <= '0;
        end else begin
            r_rw_wr_pulse <= '0;
            r_cor_clear   <= '0;

            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= s_axi.s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi.s_axi_wdata;
                r_wstrb  <= s_axi.s_axi_wstrb;
            end

            // Holding registers cannot refill while bvalid is up, so commit and B release never overlap.
            if (w_do_write) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_bresp;
                if (w_wr_dec.kind == K_RW) begin
                    for (int i = 0; i < C_NUM_RW; i++) begin
                        if (w_wr_dec.idx == 5'(i)) begin
                            r_rw_wr_pulse[i] <= 1'b1;
                            for (int b = 0; b < 4; b++)
                                if (r_wstrb[b]) r_rw_regs[32*i + 8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end else if (r_bvalid && s_axi.s_axi_bready) begin
                r_bvalid <= 1'b0;
            end

            // Read samples pre-write register values, so a same-edge write returns old data.
            if (w_ar_hs) begin
                r_rvalid    <= 1'b1;
                r_rdata     <= w_rdata;
                r_rresp     <= w_rresp;
                r_cor_clear <= w_cor_hit;
            end else if (r_rvalid && s_axi.s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi.s_axi_awready = w_awready;
    assign s_axi.s_axi_wready  = w_wready;
    assign s_axi.s_axi_arready = w_arready;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;
    assign rw_regs             = r_rw_regs;
    assign rw_wr_pulse         = r_rw_wr_pulse;
    assign cor_clear           = r_cor_clear;

endmodule

// File: tb/tb_wombat_axil_regbank.sv
// tb/tb_wombat_axil_regbank.sv - directed scoreboard bench for wombat_axil_regbank
module tb_wombat_axil_regbank;

    localparam logic [127:0] DEF = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    localparam logic [31:0]  ID  = 32'h5744_0001;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [127:0] rw_regs;
    logic [3:0]   rw_wr_pulse;
    logic [127:0] ro_regs = '0;
    logic [63:0]  cor_regs = '0;
    logic [1:0]   cor_clear;

    int checks = 0;
    int failures = 0;

    logic [1:0]   bq[$];
    logic [33:0]  rq[$];
    logic [127:0] m_rw = DEF;

    wombat_axil_regbank_if #(.C_ADDR_WIDTH(32)) axi ();

    wombat_axil_regbank #(
        .C_ADDR_WIDTH  (32),
        .C_BASE_ADDRESS(32'h0000_0000),
        .C_ID_VALUE    (ID),
        .C_NUM_RW      (4),
        .C_NUM_RO      (4),
        .C_NUM_COR     (2),
        .C_RW_DEFAULT  (DEF)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_axi      (axi),
        .rw_regs    (rw_regs),
        .rw_wr_pulse(rw_wr_pulse),
        .ro_regs    (ro_regs),
        .cor_regs   (cor_regs),
        .cor_clear  (cor_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) m_rw[32*idx + 8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] resp);
        bq.push_back(resp);
        axi.s_axi_awaddr  = a;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wdata   = d;
        axi.s_axi_wstrb   = s;
        axi.s_axi_wvalid  = 1'b1;
    endtask

    task automatic finish_write(input logic [3:0] exp_pulse);
        int  n;
        bit  aw_hs, w_hs;
        n = 0;
        while ((axi.s_axi_awvalid || axi.s_axi_wvalid) && n < 50) begin
            aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
            w_hs  = axi.s_axi_wvalid && axi.s_axi_wready;
            tick;
            if (aw_hs) axi.s_axi_awvalid = 1'b0;
            if (w_hs)  axi.s_axi_wvalid  = 1'b0;
            n++;
        end
        n = 0;
        while (!axi.s_axi_bvalid && n < 20) begin
            tick;
            n++;
        end
        check("b_latency", 128'(n), 128'd1);
        check("bvalid", 128'(axi.s_axi_bvalid), 128'd1);
        check("wr_pulse", 128'(rw_wr_pulse), 128'(exp_pulse));
        check("rw_regs", rw_regs, m_rw);
        check("bresp", 128'(axi.s_axi_bresp), 128'(bq.pop_front()));
        axi.s_axi_bready = 1'b1;
        tick;
        axi.s_axi_bready = 1'b0;
        check("bvalid_clr", 128'(axi.s_axi_bvalid), 128'd0);
        check("wr_pulse_clr", 128'(rw_wr_pulse), 128'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp, input logic [3:0] exp_pulse);
        start_write(a, d, s, resp);
        finish_write(exp_pulse);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int delay, input int cor_bit);
        int           n;
        logic [33:0]  e;
        logic [1:0]   exp_clr;
        rq.push_back({exp_d, exp_r});
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        n = 0;
        while (!axi.s_axi_arready && n < 20) begin
            tick;
            n++;
        end
        tick;
        axi.s_axi_arvalid = 1'b0;
        check("rvalid", 128'(axi.s_axi_rvalid), 128'd1);
        e = rq.pop_front();
        for (int k = 0; k <= delay; k++) begin
            exp_clr = (cor_bit >= 0 && k == 0) ? 2'(1 << cor_bit) : 2'b00;
            check("cor_clear", 128'(cor_clear), 128'(exp_clr));
            check("rdata", 128'(axi.s_axi_rdata), 128'(e[33:2]));
            if (k == 0) check("rresp", 128'(axi.s_axi_rresp), 128'(e[1:0]));
            if (k < delay) tick;
        end
        axi.s_axi_rready = 1'b1;
        tick;
        axi.s_axi_rready = 1'b0;
        check("rvalid_clr", 128'(axi.s_axi_rvalid), 128'd0);
    endtask

    initial begin
        axi.s_axi_awaddr  = '0;
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata   = '0;
        axi.s_axi_wstrb   = '0;
        axi.s_axi_wvalid  = 1'b0;
        axi.s_axi_bready  = 1'b0;
        axi.s_axi_araddr  = '0;
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready  = 1'b0;
        ro_regs  = {32'hD0D0_0003, 32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
        cor_regs = {32'd99, 32'd77};

        repeat (3) tick;
        check("rst_awready", 128'(axi.s_axi_awready), 128'd0);
        check("rst_wready", 128'(axi.s_axi_wready), 128'd0);
        check("rst_arready", 128'(axi.s_axi_arready), 128'd0);
        check("rst_bvalid", 128'(axi.s_axi_bvalid), 128'd0);
        check("rst_rvalid", 128'(axi.s_axi_rvalid), 128'd0);
        check("rst_rdata", 128'(axi.s_axi_rdata), 128'd0);
        check("rst_rw_regs", rw_regs, DEF);
        check("rst_pulse", 128'({rw_wr_pulse, cor_clear}), 128'd0);
        resetn = 1'b1;
        tick;

        do_read(32'h010, DEF[31:0], 2'b00, 0, -1);
        do_read(32'h000, ID, 2'b00, 0, -1);

        // W leads AW by three cycles.
        bq.push_back(2'b00);
        axi.s_axi_wdata  = 32'hA5A5_1234;
        axi.s_axi_wstrb  = 4'b0011;
        axi.s_axi_wvalid = 1'b1;
        tick;
        axi.s_axi_wvalid = 1'b0;
        check("w_held_wready", 128'(axi.s_axi_wready), 128'd0);
        tick;
        tick;
        axi.s_axi_awaddr  = 32'h014;
        axi.s_axi_awvalid = 1'b1;
        check("aw_ready", 128'(axi.s_axi_awready), 128'd1);
        tick;
        axi.s_axi_awvalid = 1'b0;
        check("wfirst_bvalid_early", 128'(axi.s_axi_bvalid), 128'd0);
        check("wfirst_rw_early", rw_regs, m_rw);
        model_write(1, 32'hA5A5_1234, 4'b0011);
        tick;
        check("wfirst_bvalid", 128'(axi.s_axi_bvalid), 128'd1);
        check("wfirst_reg1", 128'(rw_regs[63:32]), 128'(m_rw[63:32]));
        check("wfirst_pulse", 128'(rw_wr_pulse), 128'b0010);
        tick;
        check("wfirst_pulse_once", 128'(rw_wr_pulse), 128'd0);

        // B backpressure with a second write already offered.
        start_write(32'h018, 32'hCAFE_F00D, 4'b1111, 2'b00);
        for (int k = 0; k < 5; k++) begin
            check("bp_bvalid", 128'(axi.s_axi_bvalid), 128'd1);
            check("bp_ready", 128'({axi.s_axi_awready, axi.s_axi_wready}), 128'd0);
            tick;
        end
        check("bp_bresp", 128'(axi.s_axi_bresp), 128'(bq.pop_front()));
        check("bp_reg2_untouched", 128'(rw_regs[95:64]), 128'(m_rw[95:64]));
        axi.s_axi_bready = 1'b1;
        tick;
        axi.s_axi_bready = 1'b0;
        check("bp_bvalid_clr", 128'(axi.s_axi_bvalid), 128'd0);
        model_write(2, 32'hCAFE_F00D, 4'b1111);
        finish_write(4'b0100);

        do_write(32'h010, 32'hFFFF_FFFF, 4'b0000, 2'b00, 4'b0001);
        model_write(3, 32'h8765_4321, 4'b1100);
        do_write(32'h01E, 32'h8765_4321, 4'b1100, 2'b00, 4'b1000);
        do_read(32'h01C, m_rw[127:96], 2'b00, 1, -1);

        do_read(32'h200, 32'd77, 2'b00, 4, 0);
        do_read(32'h204, 32'd99, 2'b00, 0, 1);
        do_read(32'h104, 32'hB0B0_0001, 2'b00, 0, -1);

        do_write(32'h100, 32'h1234_5678, 4'b1111, 2'b10, 4'b0000);
        do_read(32'h100, 32'hA0A0_0000, 2'b00, 0, -1);
        do_write(32'h000, 32'h1234_5678, 4'b1111, 2'b10, 4'b0000);
        do_read(32'h800, 32'hDEAD_BEEF, 2'b11, 0, -1);
        do_read(32'h020, 32'hDEAD_BEEF, 2'b11, 0, -1);
        do_write(32'h1004, 32'h1234_5678, 4'b1111, 2'b11, 4'b0000);

        // Reset with AW captured and W still pending.
        axi.s_axi_awaddr  = 32'h010;
        axi.s_axi_awvalid = 1'b1;
        tick;
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata   = 32'h0BAD_0BAD;
        axi.s_axi_wstrb   = 4'b1111;
        axi.s_axi_wvalid  = 1'b1;
        resetn = 1'b0;
        tick;
        tick;
        check("mid_rst_bvalid", 128'(axi.s_axi_bvalid), 128'd0);
        check("mid_rst_ready", 128'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 128'd0);
        check("mid_rst_rw", rw_regs, DEF);
        axi.s_axi_wvalid = 1'b0;
        resetn = 1'b1;
        m_rw = DEF;
        tick;
        tick;
        check("post_rst_bvalid", 128'(axi.s_axi_bvalid), 128'd0);
        check("post_rst_rw", rw_regs, DEF);
        model_write(0, 32'h5555_AAAA, 4'b1111);
        do_write(32'h010, 32'h5555_AAAA, 4'b1111, 2'b00, 4'b0001);
        do_read(32'h010, 32'h5555_AAAA, 2'b00, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
